// File: rtl/rx_autobaud_ctrl.sv
// rx_autobaud_ctrl: measures line bit rate from a 0x55 sync character, programs the
// UART receiver, gates its serial input until lock and drains received bytes.
`default_nettype none

module rx_autobaud_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic        start_cal,
  input  logic [3:0]  cfg_data_size,
  input  logic        data_ready,
  input  logic        overrun_error,
  input  logic        framing_error,
  input  logic [7:0]  rx_data,
  output logic        rx_serial,
  output logic [13:0] bit_period,
  output logic [3:0]  data_size,
  output logic        data_read,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ack,
  output logic        locked,
  output logic        cal_error
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    MEASURE    = 3'd2,
    SETTLE     = 3'd3,
    LOCKED     = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [16:0] CNT_TIMEOUT = 17'd131068;

  state_t      state, next_state;
  logic        sync1, s, s_d;
  logic        fall, rise;
  logic [16:0] cnt;
  logic [2:0]  fall_cnt;
  logic [1:0]  err_cnt;
  logic        fe_d, fe_rise;
  logic [17:0] meas;
  logic        meas_ok;
  logic        clr_meas, load_bp, capture;
  logic        unused_inputs;

  assign unused_inputs = overrun_error;

  // Line idles high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign fall    = s_d & ~s;
  assign rise    = ~s_d & s;
  assign fe_rise = framing_error & ~fe_d;

  // cnt holds N-1 on the closing edge, so +5 gives the rounded (N+4)>>3.
  assign meas    = ({1'b0, cnt} + 18'd5) >> 3;
  assign meas_ok = (meas >= 18'd16) && (meas <= 18'd16383);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    clr_meas   = 1'b0;
    load_bp    = 1'b0;
    capture    = 1'b0;
    if (start_cal) begin
      next_state = WAIT_START;
    end else begin
      case (state)
        IDLE: ;
        WAIT_START: begin
          if (fall) begin
            clr_meas   = 1'b1;
            next_state = MEASURE;
          end
        end
        MEASURE: begin
          if (fall && (fall_cnt == 3'd3)) begin
            if (meas_ok) begin
              load_bp    = 1'b1;
              next_state = SETTLE;
            end else begin
              next_state = ERROR;
            end
          end else if (cnt == CNT_TIMEOUT) begin
            next_state = ERROR;
          end
        end
        SETTLE: begin
          if (rise) next_state = LOCKED;
        end
        LOCKED: begin
          capture = data_ready & ~byte_valid & ~data_read;
          if (fe_rise && (err_cnt == 2'd2)) next_state = WAIT_START;
        end
        ERROR: ;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt      <= '0;
      fall_cnt <= '0;
    end else if (clr_meas) begin
      cnt      <= '0;
      fall_cnt <= '0;
    end else if (state == MEASURE) begin
      cnt <= cnt + 17'd1;
      if (fall) fall_cnt <= fall_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fe_d    <= 1'b0;
      err_cnt <= '0;
    end else begin
      fe_d <= framing_error;
      if (start_cal || capture) begin
        err_cnt <= '0;
      end else if ((state == LOCKED) && fe_rise) begin
        err_cnt <= (err_cnt == 2'd2) ? 2'd0 : err_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_period <= 14'd10;
      data_size  <= 4'd8;
    end else begin
      if (load_bp) bit_period <= meas[13:0];
      if (start_cal) begin
        data_size <= ((cfg_data_size >= 4'd5) && (cfg_data_size <= 4'd8)) ? cfg_data_size : 4'd8;
      end
    end
  end

  // Ack clears before a new capture is considered; capture needs byte_valid low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_read  <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      data_read <= capture;
      if (capture) byte_out <= rx_data;
      if (start_cal)     byte_valid <= 1'b0;
      else if (capture)  byte_valid <= 1'b1;
      else if (byte_ack) byte_valid <= 1'b0;
    end
  end

  assign locked    = (state == LOCKED);
  assign cal_error = (state == ERROR);
  assign rx_serial = (state == LOCKED) ? s : 1'b1;

endmodule

`default_nettype wire
